// File: rtl/answer_window_pkg.sv
// Shared types, segment patterns and digit helpers for the answer-window controller.
package answer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_POST = 2'd2
  } state_e;

  // Active-low {dp,g,f,e,d,c,b,a}; dp is always off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DIGIT [0:9] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
    8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
  };

  function automatic logic [6:0] clamp99(input logic [31:0] v);
    logic [6:0] r;
    if (v > 32'd99) begin
      r = 7'd99;
    end else begin
      r = 7'(v);
    end
    return r;
  endfunction

  // Split a 0..99 value into {tens, ones} BCD nibbles.
  function automatic logic [7:0] to_bcd(input logic [6:0] v);
    return {4'(v / 7'd10), 4'(v % 7'd10)};
  endfunction

endpackage

// File: rtl/answer_window_if.sv
// Control handshake between the game sequencer and the answer-window controller.
interface answer_window_if;
  logic       answerSig;
  logic       abortSig;
  logic       active;
  logic [6:0] timeLeft;
  logic       postSig;
  logic       stopCount;

  modport master (
    output answerSig, abortSig,
    input  active, timeLeft, postSig, stopCount
  );

  modport slave (
    input  answerSig, abortSig,
    output active, timeLeft, postSig, stopCount
  );
endinterface

// File: rtl/answer_window_seg7_digit_enc.sv
// BCD digit to active-low 7-segment pattern; anything above 9 blanks the digit.
module seg7_digit_enc
  import answer_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  // Pattern lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG_DIGIT[0];
      4'd1:    seg = SEG_DIGIT[1];
      4'd2:    seg = SEG_DIGIT[2];
      4'd3:    seg = SEG_DIGIT[3];
      4'd4:    seg = SEG_DIGIT[4];
      4'd5:    seg = SEG_DIGIT[5];
      4'd6:    seg = SEG_DIGIT[6];
      4'd7:    seg = SEG_DIGIT[7];
      4'd8:    seg = SEG_DIGIT[8];
      4'd9:    seg = SEG_DIGIT[9];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/answer_window.sv
// Timed answer-period controller: countdown, close pulses, leader/tie capture and
// the four-digit score/time display.
module answer_window
  import answer_pkg::*;
#(
  parameter int CLK_HZ      = 100_000_000,
  parameter int WINDOW_SECS = 5,
  parameter int NUM_PLAYERS = 2,
  parameter int COUNT_W     = 7,
  localparam int PW         = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           Clk100M,
  input  logic                           Reset,
  answer_window_if.slave                 ctl,
  input  logic [NUM_PLAYERS*COUNT_W-1:0] userCount,
  input  logic [PW-1:0]                  dispSel,
  output logic [PW-1:0]                  leader,
  output logic                           tie,
  output logic [7:0]                     answerSeg0,
  output logic [7:0]                     answerSeg1,
  output logic [7:0]                     answerSeg2,
  output logic [7:0]                     answerSeg3
);

  localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(CLK_HZ - 1);

  if (WINDOW_SECS < 1 || WINDOW_SECS > 99) begin : g_bad_window
    $error("answer_window: WINDOW_SECS must be within 1..99");
  end
  if (NUM_PLAYERS < 1) begin : g_bad_players
    $error("answer_window: NUM_PLAYERS must be at least 1");
  end

  state_e             state_r;
  logic [PRE_W-1:0]   pre_r;
  logic               active_r;
  logic [6:0]         time_r;
  logic               post_r;
  logic [PW-1:0]      leader_r;
  logic               tie_r;
  logic [7:0]         seg0_r, seg1_r, seg2_r, seg3_r;

  logic               tick_s;
  logic [COUNT_W-1:0] max_s, cnt_s, sel_cnt_s;
  logic [PW-1:0]      lead_s;
  logic               tie_s;
  logic [7:0]         cnt_bcd_s, time_bcd_s;
  logic [7:0]         enc0_s, enc1_s, enc2_s, enc3_s;

  assign tick_s = (pre_r == PRE_TC);

  // Leader/tie compare: strict greater keeps the lowest index on equal maxima
  always_comb begin
    max_s  = userCount[0 +: COUNT_W];
    cnt_s  = '0;
    lead_s = '0;
    tie_s  = 1'b0;
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      cnt_s = userCount[p*COUNT_W +: COUNT_W];
      if (cnt_s > max_s) begin
        max_s  = cnt_s;
        lead_s = PW'(p);
        tie_s  = 1'b0;
      end else if (cnt_s == max_s) begin
        tie_s = 1'b1;
      end else begin
        tie_s = tie_s;
      end
    end
  end

  // Display player select; out-of-range selects fall back to player 0
  always_comb begin
    sel_cnt_s = userCount[0 +: COUNT_W];
    for (int p = 1; p < NUM_PLAYERS; p++) begin
      if (dispSel == PW'(p)) begin
        sel_cnt_s = userCount[p*COUNT_W +: COUNT_W];
      end else begin
        sel_cnt_s = sel_cnt_s;
      end
    end
  end

  assign cnt_bcd_s  = to_bcd(clamp99(32'(sel_cnt_s)));
  assign time_bcd_s = active_r ? to_bcd(time_r) : 8'hFF;

  seg7_digit_enc u_enc0 (.bcd(cnt_bcd_s[7:4]),  .seg(enc0_s));
  seg7_digit_enc u_enc1 (.bcd(cnt_bcd_s[3:0]),  .seg(enc1_s));
  seg7_digit_enc u_enc2 (.bcd(time_bcd_s[7:4]), .seg(enc2_s));
  seg7_digit_enc u_enc3 (.bcd(time_bcd_s[3:0]), .seg(enc3_s));

  // Window FSM with prescaler, countdown and close-time capture
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      pre_r    <= '0;
      active_r <= 1'b0;
      time_r   <= 7'd0;
      post_r   <= 1'b0;
      leader_r <= '0;
      tie_r    <= 1'b0;
    end else begin
      post_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (ctl.answerSig) begin
            state_r  <= ST_RUN;
            active_r <= 1'b1;
            time_r   <= 7'(WINDOW_SECS);
            pre_r    <= '0;
          end
        end
        ST_RUN: begin
          pre_r <= tick_s ? '0 : pre_r + 1'b1;
          // Final tick wins over a coincident abort so the time reads zero
          if ((tick_s && time_r == 7'd1) || ctl.abortSig) begin
            state_r  <= ST_POST;
            active_r <= 1'b0;
            post_r   <= 1'b1;
            leader_r <= lead_s;
            tie_r    <= tie_s;
            if (tick_s && time_r == 7'd1) begin
              time_r <= 7'd0;
            end
          end else if (tick_s) begin
            time_r <= time_r - 7'd1;
          end
        end
        ST_POST: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r  <= ST_IDLE;
          active_r <= 1'b0;
        end
      endcase
    end
  end

  // Registered segment drivers
  always_ff @(posedge Clk100M) begin
    if (Reset) begin
      seg0_r <= SEG_DIGIT[0];
      seg1_r <= SEG_DIGIT[0];
      seg2_r <= SEG_BLANK;
      seg3_r <= SEG_BLANK;
    end else begin
      seg0_r <= enc0_s;
      seg1_r <= enc1_s;
      seg2_r <= enc2_s;
      seg3_r <= enc3_s;
    end
  end

  assign ctl.active    = active_r;
  assign ctl.timeLeft  = time_r;
  assign ctl.postSig   = post_r;
  assign ctl.stopCount = post_r;
  assign leader        = leader_r;
  assign tie           = tie_r;
  assign answerSeg0    = seg0_r;
  assign answerSeg1    = seg1_r;
  assign answerSeg2    = seg2_r;
  assign answerSeg3    = seg3_r;

endmodule

// File: tb/tb_answer_window.sv
// Directed bench for answer_window at CLK_HZ=10, five-second window, three players.
module tb_answer_window;

  localparam int NP = 3;
  localparam int CW = 7;
  localparam int PW = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NP*CW-1:0] user_count;
  logic [PW-1:0]    disp_sel;
  logic [PW-1:0]    leader;
  logic             tie;
  logic [7:0]       seg0, seg1, seg2, seg3;

  int tests_run    = 0;
  int tests_failed = 0;

  answer_window_if ctl();

  answer_window #(
    .CLK_HZ      (10),
    .WINDOW_SECS (5),
    .NUM_PLAYERS (NP),
    .COUNT_W     (CW)
  ) dut (
    .Clk100M    (clk),
    .Reset      (rst),
    .ctl        (ctl.slave),
    .userCount  (user_count),
    .dispSel    (disp_sel),
    .leader     (leader),
    .tie        (tie),
    .answerSeg0 (seg0),
    .answerSeg1 (seg1),
    .answerSeg2 (seg2),
    .answerSeg3 (seg3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    tests_run++;
    if (obs != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  // Advance n cycles; outputs are then sampled 1 ns after the edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ctl.answerSig = 1'b0;
    ctl.abortSig  = 1'b0;
    user_count    = {7'd9, 7'd9, 7'd4};
    disp_sel      = 2'd0;
    rst           = 1'b1;
    step(2);

    check("rst_active", int'(ctl.active), 0);
    check("rst_time",   int'(ctl.timeLeft), 0);
    check("rst_post",   int'(ctl.postSig), 0);
    check("rst_stop",   int'(ctl.stopCount), 0);
    check("rst_leader", int'(leader), 0);
    check("rst_tie",    int'(tie), 0);
    check("rst_seg0",   int'(seg0), 'hC0);
    check("rst_seg1",   int'(seg1), 'hC0);
    check("rst_seg2",   int'(seg2), 'hFF);
    check("rst_seg3",   int'(seg3), 'hFF);
    rst = 1'b0;

    // Abort in IDLE must do nothing
    ctl.abortSig = 1'b1;
    step(1);
    ctl.abortSig = 1'b0;
    check("idle_abort_active", int'(ctl.active), 0);
    check("idle_abort_post",   int'(ctl.postSig), 0);
    step(1);
    check("idle_seg0_p0", int'(seg0), 'hC0);
    check("idle_seg1_p0", int'(seg1), 'h99);

    // Nominal window: counts {4,9,9} -> leader 1, tie
    ctl.answerSig = 1'b1;
    step(1);
    ctl.answerSig = 1'b0;
    check("nom_seg2_first", int'(seg2), 'hFF);
    for (int i = 1; i <= 50; i++) begin
      check("nom_active", int'(ctl.active), 1);
      check("nom_time",   int'(ctl.timeLeft), 5 - (i - 1) / 10);
      check("nom_post_low", int'(ctl.postSig), 0);
      if (i == 2) begin
        check("nom_seg2", int'(seg2), 'hC0);
        check("nom_seg3", int'(seg3), 'h92);
      end
      step(1);
    end
    check("nom_end_active", int'(ctl.active), 0);
    check("nom_end_post",   int'(ctl.postSig), 1);
    check("nom_end_stop",   int'(ctl.stopCount), 1);
    check("nom_end_time",   int'(ctl.timeLeft), 0);
    check("nom_leader",     int'(leader), 1);
    check("nom_tie",        int'(tie), 1);
    step(1);
    check("nom_post_clear", int'(ctl.postSig), 0);
    check("nom_stop_clear", int'(ctl.stopCount), 0);
    check("nom_idle_seg2",  int'(seg2), 'hFF);

    // Reset at RUN cycle 30
    ctl.answerSig = 1'b1;
    step(1);
    ctl.answerSig = 1'b0;
    step(29);
    check("mid_active_before", int'(ctl.active), 1);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("mrst_active", int'(ctl.active), 0);
    check("mrst_time",   int'(ctl.timeLeft), 0);
    check("mrst_post",   int'(ctl.postSig), 0);
    check("mrst_stop",   int'(ctl.stopCount), 0);
    check("mrst_leader", int'(leader), 0);
    check("mrst_tie",    int'(tie), 0);
    check("mrst_seg0",   int'(seg0), 'hC0);
    check("mrst_seg1",   int'(seg1), 'hC0);
    check("mrst_seg2",   int'(seg2), 'hFF);
    check("mrst_seg3",   int'(seg3), 'hFF);
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("mrst_no_post",   int'(ctl.postSig), 0);
      check("mrst_no_active", int'(ctl.active), 0);
    end

    // Abort at RUN cycle 23 with counts {12,3,0}
    user_count = {7'd0, 7'd3, 7'd12};
    ctl.answerSig = 1'b1;
    step(1);
    ctl.answerSig = 1'b0;
    step(22);
    ctl.abortSig = 1'b1;
    step(1);
    ctl.abortSig = 1'b0;
    check("abort_post",   int'(ctl.postSig), 1);
    check("abort_stop",   int'(ctl.stopCount), 1);
    check("abort_active", int'(ctl.active), 0);
    check("abort_time",   int'(ctl.timeLeft), 3);
    check("abort_leader", int'(leader), 0);
    check("abort_tie",    int'(tie), 0);
    check("abort_seg2",   int'(seg2), 'hC0);
    check("abort_seg3",   int'(seg3), 'hB0);
    step(1);
    check("abort_post_clear", int'(ctl.postSig), 0);
    check("abort_idle_seg2",  int'(seg2), 'hFF);
    check("abort_idle_seg3",  int'(seg3), 'hFF);
    check("abort_time_hold",  int'(ctl.timeLeft), 3);

    // All-zero counts at close are a tie on player 0
    user_count = '0;
    ctl.answerSig = 1'b1;
    step(1);
    ctl.answerSig = 1'b0;
    step(3);
    ctl.abortSig = 1'b1;
    step(1);
    ctl.abortSig = 1'b0;
    check("zero_leader", int'(leader), 0);
    check("zero_tie",    int'(tie), 1);
    step(1);

    // Display clamp and select fallback
    user_count = {7'd123, 7'd3, 7'd12};
    disp_sel   = 2'd2;
    step(1);
    check("disp_clamp_seg0", int'(seg0), 'h90);
    check("disp_clamp_seg1", int'(seg1), 'h90);
    disp_sel = 2'd3;
    step(1);
    check("disp_oor_seg0", int'(seg0), 'hF9);
    check("disp_oor_seg1", int'(seg1), 'hA4);
    disp_sel = 2'd1;
    step(1);
    check("disp_p1_seg0", int'(seg0), 'hC0);
    check("disp_p1_seg1", int'(seg1), 'hB0);
    check("disp_idle_seg2", int'(seg2), 'hFF);

    // answerSig held high: single window, then immediate restart
    ctl.answerSig = 1'b1;
    step(1);
    step(44);
    check("held_time_c45", int'(ctl.timeLeft), 1);
    check("held_active_c45", int'(ctl.active), 1);
    step(5);
    check("held_active_c50", int'(ctl.active), 1);
    step(1);
    check("held_post",   int'(ctl.postSig), 1);
    check("held_active_post", int'(ctl.active), 0);
    step(1);
    check("held_idle_active", int'(ctl.active), 0);
    check("held_idle_post",   int'(ctl.postSig), 0);
    step(1);
    ctl.answerSig = 1'b0;
    check("restart_active", int'(ctl.active), 1);
    check("restart_time",   int'(ctl.timeLeft), 5);

    // Abort coincident with the final tick
    step(49);
    check("coinc_active_c50", int'(ctl.active), 1);
    check("coinc_time_c50",   int'(ctl.timeLeft), 1);
    ctl.abortSig = 1'b1;
    step(1);
    ctl.abortSig = 1'b0;
    check("coinc_post",   int'(ctl.postSig), 1);
    check("coinc_time",   int'(ctl.timeLeft), 0);
    check("coinc_active", int'(ctl.active), 0);
    step(1);
    check("coinc_post_once_a", int'(ctl.postSig), 0);
    step(1);
    check("coinc_post_once_b", int'(ctl.postSig), 0);
    check("coinc_idle_active", int'(ctl.active), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/answer_window.md
# answer_window

Parametrised, single-clock answer-period controller for the symbol-counting game. On a start pulse it opens a timed answer window of `WINDOW_SECS` seconds, then closes it by pulsing the stop and post signals. While open it drives a live seconds-remaining countdown and the selected player's count onto four 7-segment digit registers. At close it latches the leading player and a tie flag. It sits between the game sequencer, which issues `answerSig`, and the per-player symbol counters and display mux.

## Interface
- `CLK_HZ`, 100_000_000: clock frequency; also the second-tick prescaler terminal count.
- `WINDOW_SECS`, 5: window length in seconds; legal range 1..99, enforced by an elaboration-time check.
- `NUM_PLAYERS`, 2: number of player count channels, at least 1.
- `COUNT_W`, 7: width of each player count.
- `PW` is derived, not a port-visible parameter: `PW = max(1, $clog2(NUM_PLAYERS))`.

Ports (name, direction, width, meaning):
- `Clk100M` in 1: the single clock.
- `Reset` in 1: reset, synchronous and active-high.
- `answerSig` in 1: window start request, level or pulse.
- `abortSig` in 1: close the window early.
- `userCount` in NUM_PLAYERS*COUNT_W: packed player counts; player p occupies bits [p*COUNT_W +: COUNT_W].
- `dispSel` in PW: selects the player shown on digits 0/1.
- `active` out 1: high while the window is open.
- `timeLeft` out 7: seconds remaining.
- `postSig` out 1: one-cycle pulse when the window closes.
- `stopCount` out 1: one-cycle pulse, identical in timing to `postSig`.
- `leader` out PW: index of the player with the highest count at close.
- `tie` out 1: high when two or more players share the maximum at close.
- `answerSeg0` … `answerSeg3` out 8 each: digit patterns, bit order {dp,g,f,e,d,c,b,a}, active-low, dp always off.

## Operation
- States: IDLE, RUN, POST.
- IDLE:
  - `answerSig`=1 → RUN, loading `timeLeft`=WINDOW_SECS and prescaler=0.
  - `abortSig` is ignored.
- RUN:
  - The prescaler counts 0..CLK_HZ-1 and wraps. `tick` = (prescaler==CLK_HZ-1).
  - On `tick`, `timeLeft` decrements.
  - On `tick` with `timeLeft`==1: `timeLeft`←0, go to POST.
  - `abortSig`=1 → POST; `timeLeft` holds its current value.
  - Abort and the final tick in the same cycle → one POST; `timeLeft`←0.
  - `answerSig` is ignored; there is no restart.
- POST:
  - Lasts exactly one cycle, with `postSig`=`stopCount`=1, then returns to IDLE.
  - `answerSig` is ignored in POST.
- Leader and tie:
  - On the RUN→POST edge, `leader` and `tie` are registered from the `userCount` sampled in that last RUN cycle.
  - `leader` = lowest index holding the maximum count.
  - `tie` = 1 when two or more players share the maximum; an all-zero field with NUM_PLAYERS>1 is a tie.
  - Both hold until the next POST or reset.
- Display:
  - Digits 0/1: tens and ones of the `dispSel` player's count, live in every state. Counts above 99 display as 99.
  - Digits 2/3: tens and ones of `timeLeft` while `active`; blank (8'hFF) otherwise.
  - `dispSel` ≥ NUM_PLAYERS selects player 0.
- Reset:
  - Clears state to IDLE and zeroes the prescaler.
  - Output reset values: `active`=0, `timeLeft`=0, `postSig`=0, `stopCount`=0, `leader`=0, `tie`=0, `answerSeg0`=`answerSeg1`=8'hC0 (digit "0"), `answerSeg2`=`answerSeg3`=8'hFF.
  - Reset mid-window aborts it with no `postSig`.
  - Reset has priority over every input in the same cycle.

## Timing
- `answerSig` sampled at edge k → `active`=1 and `timeLeft`=WINDOW_SECS from cycle k+1.
- `active` stays high for exactly WINDOW_SECS*CLK_HZ cycles. The first decrement lands CLK_HZ cycles after RUN entry.
- `postSig`/`stopCount` are high in the single cycle immediately after the last `active` cycle; `active`=0 in that cycle.
- Abort asserted in cycle m → POST in cycle m+1.
- Segment outputs are registered with one cycle of latency from `userCount`, `dispSel` and `timeLeft`.
- Minimum spacing between windows: a new `answerSig` is accepted on the IDLE cycle following POST.

## Structure
- Package `answer_pkg`:
  - state enum (IDLE, RUN, POST);
  - constants SEG_BLANK=8'hFF and SEG_DIGIT[0:9];
  - function `clamp99`.
- Sub-module `seg7_digit_enc`: 4-bit BCD in → 8-bit active-low pattern; values ≥10 map to blank. Instantiated four times.
- The leader/tie compare is a combinational loop over NUM_PLAYERS in the top module.

## Test plan
All scenarios use CLK_HZ=10.
1. **Nominal window:** WINDOW_SECS=5, pulse `answerSig` → `active` high for 50 cycles; `timeLeft` steps 5,4,3,2,1,0 every 10 cycles; a single `postSig`/`stopCount` pulse in cycle 51.
2. **Abort:** `abortSig` in RUN cycle 23 → `postSig` in cycle 24, `timeLeft` held at 3, `active`=0.
3. **Leader and tie:** NUM_PLAYERS=3, counts {4,9,9} at close → `leader`=1, `tie`=1. Counts {12,3,0} → `leader`=0, `tie`=0.
4. **Display:** `dispSel`=2, count 123 → seg0=digit 9, seg1=digit 9. While IDLE, seg2 and seg3 = 8'hFF.
5. **Reset mid-run:** `Reset` at RUN cycle 30 → IDLE next cycle, no `postSig`, all outputs at their reset values.
6. **Ignored and simultaneous inputs:** `answerSig` held high through RUN and POST → a single window, then a new window starts in the first IDLE cycle. `abortSig` coincident with the final tick → exactly one `postSig`.
